// File: rtl/interfaz_dac_spi.sv
`default_nettype none
// ============================================================================
// Module      : interfaz_dac_spi
// Description : Output stage of the filter chain. Converts each filtered
//               sample Yk (signed, FRAC fractional bits) into a saturated
//               12-bit offset-binary code and shifts it out as a 16-bit SPI
//               frame to a DAC121S101-class converter (PmodDA2).
//               Frame: 2 don't-care zeros, PD=00, then code[11:0], MSB first.
//               SCLK idles high and the DAC samples on its falling edge.
// Options     : DAC_PENDIENTE_EN - when defined, a one-deep pending register
//               holds a sample that arrives while a frame is in progress and
//               sends it straight after the inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module interfaz_dac_spi #(
    parameter int N    = 25,   // sample width (FRAC+2 or more)
    parameter int FRAC = 15,   // fractional bits of Yk (11 or more)
    parameter int DIV  = 2     // Clk cycles per SCLK half-period (2 or more)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic signed [N-1:0] Yk,
    input  logic                Bandera_Listo,
    output logic                SYNC_n,
    output logic                SCLK,
    output logic                DIN,
    output logic                Ocupado,
    output logic                Bandera_Enviado,
    output logic                Error_Sobrecarga
);

    // Counter wide enough for both the SCLK half-period and the 2*DIV gap.
    localparam int            CW          = $clog2(2 * DIV) + 1;
    localparam logic [CW-1:0] C_FIN_MEDIO = CW'(DIV - 1);
    localparam logic [CW-1:0] C_FIN_GAP   = CW'(2 * DIV - 1);
    localparam logic [4:0]    C_FLANCOS   = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } estado_t;

    // ------------------------------------------------------------------
    // Sample-to-code conversion (combinational, captured at frame start)
    // ------------------------------------------------------------------
    logic        satura_d;
    logic [11:0] s12_d;
    logic [15:0] trama_d;

    // Integer part plus bit FRAC must all match the sign, else saturate.
    always_comb begin
        satura_d = ~((&Yk[N-1:FRAC]) | ~(|Yk[N-1:FRAC]));
        s12_d    = Yk[FRAC -: 12];
        if (satura_d) begin
            s12_d = Yk[N-1] ? 12'h800 : 12'h7FF;
        end
        trama_d  = {4'b0000, ~s12_d[11], s12_d[10:0]};
    end

    // Bits below the 12-bit window are intentionally discarded.
    generate
        if (FRAC > 11) begin : g_bits_bajos
            logic bits_bajos_unused;
            assign bits_bajos_unused = ^Yk[FRAC-12:0];
        end else begin : g_sin_bits_bajos
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    estado_t       estado_q;
    logic [15:0]   trama_q;       // shift register, bit 15 is next on DIN
    logic [CW-1:0] cnt_q;         // half-period / gap cycle counter
    logic [4:0]    flancos_q;     // SCLK falling edges issued this frame
    logic          arranque_q;    // first SHIFT cycle after an IDLE capture
    logic          sync_q;
    logic          sclk_q;
    logic          din_q;
    logic          ocupado_q;
    logic          enviado_q;
    logic          error_q;
    logic          salida_gap_d;
    logic          llegada_ocupado_d;

    // Last GAP cycle: the FSM leaves GAP at the coming edge.
    assign salida_gap_d      = (estado_q == GAP) && (cnt_q == C_FIN_GAP);
    // Any arrival outside IDLE is a busy arrival; the GAP exit is handled
    // inside the FSM because it can launch the next frame directly.
    assign llegada_ocupado_d = Bandera_Listo && (estado_q != IDLE) && !salida_gap_d;

`ifdef DAC_PENDIENTE_EN
    logic [15:0] pend_q;
    logic        pend_v_q;
`endif

    // Frame sequencer: IDLE capture, SCLK generation, bit shifting, gap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q   <= IDLE;
            trama_q    <= 16'h0000;
            cnt_q      <= '0;
            flancos_q  <= 5'd0;
            arranque_q <= 1'b0;
            sync_q     <= 1'b1;
            sclk_q     <= 1'b1;
            din_q      <= 1'b0;
            ocupado_q  <= 1'b0;
            enviado_q  <= 1'b0;
            error_q    <= 1'b0;
`ifdef DAC_PENDIENTE_EN
            pend_q     <= 16'h0000;
            pend_v_q   <= 1'b0;
`endif
        end else begin
            enviado_q <= 1'b0;
            error_q   <= 1'b0;

            unique case (estado_q)
                IDLE: begin
                    if (Bandera_Listo) begin
                        trama_q    <= trama_d;
                        arranque_q <= 1'b1;
                        estado_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (arranque_q) begin
                        // Outputs follow the capture by one cycle.
                        arranque_q <= 1'b0;
                        sync_q     <= 1'b0;
                        sclk_q     <= 1'b1;
                        din_q      <= trama_q[15];
                        ocupado_q  <= 1'b1;
                        cnt_q      <= '0;
                        flancos_q  <= 5'd0;
                    end else if (cnt_q == C_FIN_MEDIO) begin
                        cnt_q <= '0;
                        if (sclk_q) begin
                            // Falling edge: DIN is held, DAC samples here.
                            sclk_q    <= 1'b0;
                            flancos_q <= flancos_q + 5'd1;
                        end else if (flancos_q == C_FLANCOS) begin
                            // Rise after the 16th fall closes the frame.
                            sync_q    <= 1'b1;
                            sclk_q    <= 1'b1;
                            din_q     <= 1'b0;
                            enviado_q <= 1'b1;
                            estado_q  <= GAP;
                        end else begin
                            // Rising edge: present the next bit.
                            sclk_q  <= 1'b1;
                            din_q   <= trama_q[14];
                            trama_q <= {trama_q[14:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                GAP: begin
                    if (cnt_q == C_FIN_GAP) begin
                        cnt_q <= '0;
`ifdef DAC_PENDIENTE_EN
                        if (pend_v_q || Bandera_Listo) begin
                            // Back-to-back frame, SYNC_n falls right away.
                            trama_q   <= pend_v_q ? pend_q : trama_d;
                            din_q     <= pend_v_q ? pend_q[15] : trama_d[15];
                            sync_q    <= 1'b0;
                            sclk_q    <= 1'b1;
                            flancos_q <= 5'd0;
                            estado_q  <= SHIFT;
                            // A coincident arrival refills the freed slot.
                            pend_v_q  <= pend_v_q && Bandera_Listo;
                            if (pend_v_q && Bandera_Listo) begin
                                pend_q <= trama_d;
                            end
                        end else begin
                            ocupado_q <= 1'b0;
                            estado_q  <= IDLE;
                        end
`else
                        if (Bandera_Listo) begin
                            error_q <= 1'b1;
                        end
                        ocupado_q <= 1'b0;
                        estado_q  <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    estado_q <= IDLE;
                end
            endcase

            // Samples arriving while a frame or gap is in progress.
            if (llegada_ocupado_d) begin
`ifdef DAC_PENDIENTE_EN
                if (pend_v_q) begin
                    error_q <= 1'b1;
                end
                pend_q   <= trama_d;
                pend_v_q <= 1'b1;
`else
                error_q <= 1'b1;
`endif
            end
        end
    end

    assign SYNC_n           = sync_q;
    assign SCLK             = sclk_q;
    assign DIN              = din_q;
    assign Ocupado          = ocupado_q;
    assign Bandera_Enviado  = enviado_q;
    assign Error_Sobrecarga = error_q;

endmodule
`default_nettype wire

// File: tb/tb_interfaz_dac_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_interfaz_dac_spi
// Description : Self-checking bench for interfaz_dac_spi (N=25, FRAC=15,
//               DIV=2). A frame decoder acting as the DAC compares received
//               frames against a queue of expected codes.
// Options     : follows DAC_PENDIENTE_EN for the overload scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_interfaz_dac_spi;

    localparam int N    = 25;
    localparam int FRAC = 15;
    localparam int DIV  = 2;

    logic                Clk;
    logic                Reset_n;
    logic signed [N-1:0] Yk;
    logic                Bandera_Listo;
    logic                SYNC_n;
    logic                SCLK;
    logic                DIN;
    logic                Ocupado;
    logic                Bandera_Enviado;
    logic                Error_Sobrecarga;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] cola[$];

    interfaz_dac_spi #(.N(N), .FRAC(FRAC), .DIV(DIV)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Yk               (Yk),
        .Bandera_Listo    (Bandera_Listo),
        .SYNC_n           (SYNC_n),
        .SCLK             (SCLK),
        .DIN              (DIN),
        .Ocupado          (Ocupado),
        .Bandera_Enviado  (Bandera_Enviado),
        .Error_Sobrecarga (Error_Sobrecarga)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, act, exp);
        end
    endtask

    // Reference: arithmetic scaling to 12 bits, clamp, offset by half scale.
    function automatic logic [15:0] modelo(input logic signed [N-1:0] y);
        int q;
        q = int'(y) >>> (FRAC - 11);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return 16'(q + 2048);
    endfunction

    // One-cycle ready pulse; k is the edge that samples it.
    task automatic pulso(input logic signed [N-1:0] y, output int k);
        @(posedge Clk); #1;
        Yk            = y;
        Bandera_Listo = 1'b1;
        @(posedge Clk); #1;
        k             = cyc;
        Bandera_Listo = 1'b0;
        Yk            = N'($urandom);
    endtask

    task automatic esperar_libre();
        repeat (75) @(posedge Clk);
        #1;
        chk("ocupado_tras_trama", 32'(Ocupado), 0);
    endtask

    // DAC-side decoder: shifts DIN on each SCLK fall inside SYNC_n low.
    initial begin
        logic        en_trama;
        logic        sclk_ant;
        logic        sync_ant;
        logic [15:0] rx;
        logic [15:0] esp;
        int          nbits;
        int          nlow;
        en_trama = 1'b0;
        sclk_ant = 1'b1;
        sync_ant = 1'b1;
        rx       = '0;
        nbits    = 0;
        nlow     = 0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                en_trama = 1'b0;
            end else if (en_trama) begin
                if (SYNC_n) begin
                    chk("bits_por_trama", 32'(nbits), 16);
                    chk("sync_bajo_ciclos", 32'(nlow), 32 * DIV);
                    if (cola.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL trama_inesperada: got 0x%0h, expected no frame", rx);
                    end else begin
                        esp = cola.pop_front();
                        chk("trama", 32'(rx), 32'(esp));
                    end
                    en_trama = 1'b0;
                end else begin
                    nlow++;
                    if (sclk_ant && !SCLK) begin
                        rx = {rx[14:0], DIN};
                        nbits++;
                    end
                end
            end else if (sync_ant && !SYNC_n) begin
                en_trama = 1'b1;
                nlow     = 1;
                nbits    = 0;
                rx       = '0;
            end
            sclk_ant = SCLK;
            sync_ant = SYNC_n;
        end
    end

    typedef struct {
        logic signed [N-1:0] yk;
        logic [15:0]         esp;
    } vec_t;

    initial begin
        vec_t tabla[10];
        int   k;
        int   k2;
        int   viol;
        int   t_fall;
        int   t_env;
        int   n_env;
        int   t_libre;
        int   n_err;
        int   t_err;
        int   t_sync2;
        logic s_ant;
        logic signed [N-1:0] yr;

        tabla[0] = '{25'sd0,        16'h0800};  // zero
        tabla[1] = '{25'sh0004000,  16'h0C00};  // +0.5
        tabla[2] = '{-25'sd32768,   16'h0000};  // -1.0
        tabla[3] = '{25'sd65536,    16'h0FFF};  // +2.0 saturates
        tabla[4] = '{-25'sd131072,  16'h0000};  // -4.0 saturates
        tabla[5] = '{25'sd32767,    16'h0FFF};  // just below +1.0
        tabla[6] = '{25'sd32768,    16'h0FFF};  // +1.0 saturates
        tabla[7] = '{-25'sd16,      16'h07FF};  // -1 LSB
        tabla[8] = '{25'sd16,       16'h0801};  // +1 LSB
        tabla[9] = '{-25'sd32784,   16'h0000};  // just below -1.0

        Reset_n       = 1'b0;
        Yk            = '0;
        Bandera_Listo = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_sync_n", 32'(SYNC_n), 1);
        chk("rst_sclk", 32'(SCLK), 1);
        chk("rst_din", 32'(DIN), 0);
        chk("rst_ocupado", 32'(Ocupado), 0);
        chk("rst_enviado", 32'(Bandera_Enviado), 0);
        chk("rst_error", 32'(Error_Sobrecarga), 0);
        Reset_n = 1'b1;

        // Quiet after reset release.
        viol = 0;
        repeat (200) begin
            @(posedge Clk); #1;
            if ({SYNC_n, SCLK, DIN, Ocupado, Bandera_Enviado, Error_Sobrecarga} !== 6'b110000)
                viol++;
        end
        chk("reposo_200_ciclos", 32'(viol), 0);

        // Frame timing for Yk = 0.
        cola.push_back(16'h0800);
        pulso(25'sd0, k);
        chk("sync_n_en_k", 32'(SYNC_n), 1);
        chk("ocupado_en_k", 32'(Ocupado), 0);
        @(posedge Clk); #1;
        chk("sync_n_en_k1", 32'(SYNC_n), 0);
        chk("ocupado_en_k1", 32'(Ocupado), 1);
        chk("din_bit15_en_k1", 32'(DIN), 0);
        chk("sclk_en_k1", 32'(SCLK), 1);
        t_fall = -1; t_env = -1; n_env = 0; t_libre = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            if (!SCLK && t_fall < 0) t_fall = cyc - k;
            if (Bandera_Enviado) begin
                n_env++;
                if (t_env < 0) t_env = cyc - k;
            end
            if (!Ocupado && t_libre < 0) t_libre = cyc - k;
        end
        chk("primer_sclk_bajada", 32'(t_fall), 1 + DIV);
        chk("enviado_ciclo", 32'(t_env), 1 + 32 * DIV);
        chk("enviado_pulsos", 32'(n_env), 1);
        chk("ocupado_baja_ciclo", 32'(t_libre), 1 + 34 * DIV);

        // Conversion table.
        for (int i = 0; i < 10; i++) begin
            cola.push_back(tabla[i].esp);
            pulso(tabla[i].yk, k);
            esperar_libre();
        end

        // Random samples in the +/-2.0 range against the reference.
        for (int i = 0; i < 4; i++) begin
            yr = N'($urandom_range(0, 131071));
            yr = yr - 25'sd65536;
            cola.push_back(modelo(yr));
            pulso(yr, k);
            esperar_libre();
        end

        // Two pulses 10 cycles apart.
        cola.push_back(16'h0800);
`ifdef DAC_PENDIENTE_EN
        cola.push_back(16'h0C00);
`endif
        pulso(25'sd0, k);
        repeat (8) @(posedge Clk);
        pulso(25'sh0004000, k2);
        n_err   = Error_Sobrecarga ? 1 : 0;
        t_err   = Error_Sobrecarga ? (k2 - k) : -1;
        n_env   = 0;
        t_sync2 = -1;
        s_ant   = SYNC_n;
        for (int i = 0; i < 160; i++) begin
            @(posedge Clk); #1;
            if (Error_Sobrecarga) begin
                n_err++;
                t_err = cyc - k;
            end
            if (Bandera_Enviado) n_env++;
            if (s_ant && !SYNC_n && t_sync2 < 0) t_sync2 = cyc - k;
            s_ant = SYNC_n;
        end
`ifdef DAC_PENDIENTE_EN
        chk("doble_errores", 32'(n_err), 0);
        chk("doble_tramas", 32'(n_env), 2);
        chk("doble_sync2_ciclo", 32'(t_sync2), 1 + 34 * DIV);
`else
        chk("doble_errores", 32'(n_err), 1);
        chk("doble_error_ciclo", 32'(t_err), 10);
        chk("doble_tramas", 32'(n_env), 1);
`endif
        chk("doble_ocupado_final", 32'(Ocupado), 0);

        // Reset in the middle of a frame.
        pulso(25'sh0004000, k);
        repeat (31) @(posedge Clk);
        #1;
        chk("pre_rst_sync_n", 32'(SYNC_n), 0);
        chk("pre_rst_sclk", 32'(SCLK), 0);
        Reset_n = 1'b0;
        #1;
        chk("rst_async_sync_n", 32'(SYNC_n), 1);
        chk("rst_async_sclk", 32'(SCLK), 1);
        chk("rst_async_ocupado", 32'(Ocupado), 0);
        chk("rst_async_din", 32'(DIN), 0);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        n_env = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (Bandera_Enviado || !SYNC_n) n_env++;
        end
        chk("rst_sin_actividad", 32'(n_env), 0);
        cola.push_back(16'h0C00);
        pulso(25'sh0004000, k);
        esperar_libre();

        repeat (5) @(posedge Clk);
        #1;
        chk("cola_vacia", 32'(cola.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
